alu_pipe: RTL and testbench

- Parametrised, registered successor to the team's 32-bit combinational MIPS ALU.
- Accepts one operation per valid/ready handshake and returns a registered result with zero, overflow, cout and illegal flags.
- Adds XOR, SLTU, shifts and a sequential multi-cycle multiply.
- Sits between the decode/issue stage and writeback in the multicycle datapath.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_mul_seq.sv | 55 +++++
 rtl/alu_pipe.sv | 158 +++++++++++++++
 tb/tb_alu_pipe.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, sequencing state and op-class helper for the pipelined ALU.
package alu_pkg;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_SLTU = 4'b1000;
   localparam logic [3:0] OP_SLL  = 4'b1001;
   localparam logic [3:0] OP_SRL  = 4'b1010;
   localparam logic [3:0] OP_SRA  = 4'b1011;
   localparam logic [3:0] OP_NOR  = 4'b1100;
   localparam logic [3:0] OP_MUL  = 4'b1101;

   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } state_t;

   // Only ADD and SUB report overflow and carry.
   function automatic logic is_arith(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: one partial product per cycle, low WIDTH bits kept.
// done is high during the last step; product is valid while done is high.
module alu_mul_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH);

   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] step;

   // Bit 0 is folded in at start, so WIDTH-1 further steps finish the product.
   assign step    = mplier[0] ? mcand : '0;
   assign product = acc + step;
   assign done    = busy && (cnt == CW'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         busy   <= 1'b0;
      end else if (start) begin
         acc    <= b[0] ? a : '0;
         mcand  <= a << 1;
         mplier <= b >> 1;
         cnt    <= CW'(WIDTH - 1);
         busy   <= 1'b1;
      end else if (busy) begin
         acc    <= product;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt - CW'(1);
         if (cnt == CW'(1)) begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake and zero/overflow/cout/illegal flags.
// Define ALU_PIPE_MUL_EN to build in the multi-cycle MUL opcode.
//
//  state | meaning
//  IDLE  | single-cycle ops accepted, result register drains
//  MUL   | multiplier running, no new operations accepted
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       ctrl,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             zero,
   output logic             overflow,
   output logic             cout,
   output logic             illegal
);

   localparam int SHW = $clog2(WIDTH);

   logic             accept;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic             add_ovf;
   logic             sub_ovf;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] res;
   logic             res_ovf;
   logic             res_cout;
   logic             res_ill;

   always_comb begin
      sum      = {1'b0, a} + {1'b0, b};
      diff     = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
      add_ovf  = (a[WIDTH-1] ^ b[WIDTH-1] ^ sum[WIDTH-1]) ^ sum[WIDTH];
      sub_ovf  = (a[WIDTH-1] ^ ~b[WIDTH-1] ^ diff[WIDTH-1]) ^ diff[WIDTH];
      shamt    = b[SHW-1:0];
      res      = '0;
      res_ill  = 1'b0;
      case (ctrl)
         OP_AND:  res = a & b;
         OP_OR:   res = a | b;
         OP_ADD:  res = sum[WIDTH-1:0];
         OP_XOR:  res = a ^ b;
         OP_SUB:  res = diff[WIDTH-1:0];
         // Sign of the difference corrected for overflow gives the true signed compare.
         OP_SLT:  res = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
         OP_SLTU: res = {{(WIDTH-1){1'b0}}, ~diff[WIDTH]};
         OP_SLL:  res = a << shamt;
         OP_SRL:  res = a >> shamt;
         OP_SRA:  res = $unsigned($signed(a) >>> shamt);
         OP_NOR:  res = ~(a | b);
`ifdef ALU_PIPE_MUL_EN
         OP_MUL:  res = '0;
`endif
         default: res_ill = 1'b1;
      endcase
      res_ovf  = is_arith(ctrl) && ((ctrl == OP_SUB) ? sub_ovf : add_ovf);
      res_cout = is_arith(ctrl) && ((ctrl == OP_SUB) ? diff[WIDTH] : sum[WIDTH]);
   end

`ifdef ALU_PIPE_MUL_EN
   state_t           state;
   logic             mul_start;
   logic             mul_busy;
   logic             mul_done;
   logic [WIDTH-1:0] mul_product;

   assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
   assign accept    = in_valid && in_ready;
   assign mul_start = accept && (ctrl == OP_MUL);

   alu_mul_seq #(
      .WIDTH(WIDTH)
   ) u_mul (
      .clk    (clk),
      .rst    (rst),
      .start  (mul_start),
      .a      (a),
      .b      (b),
      .busy   (mul_busy),
      .done   (mul_done),
      .product(mul_product)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         out       <= '0;
         zero      <= 1'b0;
         overflow  <= 1'b0;
         cout      <= 1'b0;
         illegal   <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (mul_start) begin
            state     <= MUL;
            out_valid <= 1'b0;
         end else if (accept) begin
            out       <= res;
            zero      <= (res == '0);
            overflow  <= res_ovf;
            cout      <= res_cout;
            illegal   <= res_ill;
            out_valid <= 1'b1;
         end
         if ((state == MUL) && mul_busy && mul_done) begin
            out       <= mul_product;
            zero      <= (mul_product == '0);
            overflow  <= 1'b0;
            cout      <= 1'b0;
            illegal   <= 1'b0;
            out_valid <= 1'b1;
            state     <= IDLE;
         end
      end
   end
`else
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         out       <= '0;
         zero      <= 1'b0;
         overflow  <= 1'b0;
         cout      <= 1'b0;
         illegal   <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (accept) begin
            out       <= res;
            zero      <= (res == '0);
            overflow  <= res_ovf;
            cout      <= res_cout;
            illegal   <= res_ill;
            out_valid <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: vector table at full throughput, then
// backpressure, multiply (or its illegal fallback) and reset-abort sequences.
module tb_alu_pipe;
   import alu_pkg::*;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic [3:0]  ctrl;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out;
   logic        zero;
   logic        overflow;
   logic        cout;
   logic        illegal;

   int checks = 0;
   int errors = 0;

   alu_pipe #(.WIDTH(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .ctrl     (ctrl),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out      (out),
      .zero     (zero),
      .overflow (overflow),
      .cout     (cout),
      .illegal  (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] va;
      logic [31:0] vb;
      logic [31:0] eo;
      logic        ez;
      logic        ev;
      logic        ec;
      logic        ei;
   } vec_t;

   vec_t vecs[19];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] res_word();
      return {28'd0, out, zero, overflow, cout, illegal};
   endfunction

   function automatic logic [63:0] exp_word(input logic [31:0] o, input logic z, input logic v,
                                            input logic c, input logic i);
      return {28'd0, o, z, v, c, i};
   endfunction

   initial begin
      int cyc;
      logic seen;

      //          op       a             b             out           z     ovf   cout  ill
      vecs[0]  = '{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[1]  = '{OP_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[2]  = '{OP_SLT,  32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{OP_SLTU, 32'h80000000, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{OP_SRA,  32'hF0000000, 32'h00000024, 32'hFF000000, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{OP_SRL,  32'hF0000000, 32'h00000024, 32'h0F000000, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{OP_OR,   32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{OP_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{OP_NOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{OP_SLL,  32'h00000001, 32'h00000021, 32'h00000002, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[12] = '{OP_SUB,  32'h00000001, 32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[13] = '{OP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[14] = '{OP_SLT,  32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[15] = '{OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[16] = '{4'b1111, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[17] = '{4'b0100, 32'h00000003, 32'h00000004, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[18] = '{OP_SRA,  32'h70000000, 32'h00000004, 32'h07000000, 1'b0, 1'b0, 1'b0, 1'b0};

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      ctrl      = OP_AND;
      tick();
      tick();
      chk("reset_out_flags", res_word(), exp_word(32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
      chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
      rst = 1'b0;
      tick();
      chk("reset_in_ready", {63'd0, in_ready}, 64'd1);

      // Back-to-back at full throughput: each result appears one cycle after its accept.
      for (int i = 0; i < 19; i++) begin
         in_valid = 1'b1;
         ctrl     = vecs[i].op;
         a        = vecs[i].va;
         b        = vecs[i].vb;
         #1;
         chk($sformatf("vec%0d_in_ready", i), {63'd0, in_ready}, 64'd1);
         tick();
         chk($sformatf("vec%0d_valid", i), {63'd0, out_valid}, 64'd1);
         chk($sformatf("vec%0d_result", i), res_word(),
             exp_word(vecs[i].eo, vecs[i].ez, vecs[i].ev, vecs[i].ec, vecs[i].ei));
      end
      in_valid = 1'b0;
      tick();
      chk("drain_valid_low", {63'd0, out_valid}, 64'd0);

      // Backpressure: AND result held for 3 cycles while an OR waits.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      ctrl      = OP_AND;
      a         = 32'h0000FFFF;
      b         = 32'h00FF00FF;
      tick();
      ctrl = OP_OR;
      a    = 32'h0F000000;
      b    = 32'h000000F0;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("bp%0d_valid", k), {63'd0, out_valid}, 64'd1);
         chk($sformatf("bp%0d_in_ready", k), {63'd0, in_ready}, 64'd0);
         chk($sformatf("bp%0d_hold", k), res_word(), exp_word(32'h000000FF, 1'b0, 1'b0, 1'b0, 1'b0));
         tick();
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
      tick();
      chk("bp_new_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_new_result", res_word(), exp_word(32'h0F0000F0, 1'b0, 1'b0, 1'b0, 1'b0));
      in_valid = 1'b0;
      tick();
      chk("bp_drained", {63'd0, out_valid}, 64'd0);

      // Multiply, with an ADD offered throughout.
      in_valid = 1'b1;
      ctrl     = OP_MUL;
      a        = 32'h00010003;
      b        = 32'h00000005;
      tick();
`ifdef ALU_PIPE_MUL_EN
      ctrl = OP_ADD;
      a    = 32'h00000001;
      b    = 32'h00000002;
      cyc  = 1;
      seen = 1'b0;
      while (!out_valid && cyc < 40) begin
         if (in_ready) seen = 1'b1;
         tick();
         cyc++;
      end
      chk("mul_in_ready_low", {63'd0, seen}, 64'd0);
      chk("mul_latency", 64'(cyc), 64'd32);
      chk("mul_result", res_word(), exp_word(32'h0005000F, 1'b0, 1'b0, 1'b0, 1'b0));
      chk("mul_idle_in_ready", {63'd0, in_ready}, 64'd1);
      tick();
      chk("mul_then_add", res_word(), exp_word(32'h00000003, 1'b0, 1'b0, 1'b0, 1'b0));
      in_valid = 1'b0;
      tick();

      // Reset in the middle of a multiply.
      in_valid = 1'b1;
      ctrl     = OP_MUL;
      a        = 32'h00000007;
      b        = 32'h00000009;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 10; k++) tick();
      chk("mid_mul_in_ready", {63'd0, in_ready}, 64'd0);
      rst = 1'b1;
      tick();
      chk("abort_valid", {63'd0, out_valid}, 64'd0);
      chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
      chk("abort_outputs", res_word(), exp_word(32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
      rst  = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (out_valid) seen = 1'b1;
      end
      chk("abort_no_result", {63'd0, seen}, 64'd0);
`else
      chk("mul_illegal_valid", {63'd0, out_valid}, 64'd1);
      chk("mul_illegal_result", res_word(), exp_word(32'h0, 1'b1, 1'b0, 1'b0, 1'b1));
      in_valid = 1'b0;
      tick();

      // Reset with a result pending clears everything.
      in_valid  = 1'b1;
      out_ready = 1'b0;
      ctrl      = OP_OR;
      a         = 32'h00000011;
      b         = 32'h00000100;
      tick();
      in_valid = 1'b0;
      chk("pre_rst_result", res_word(), exp_word(32'h00000111, 1'b0, 1'b0, 1'b0, 1'b0));
      rst = 1'b1;
      tick();
      chk("rst_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_outputs", res_word(), exp_word(32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
      rst       = 1'b0;
      out_ready = 1'b1;
      tick();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
